// File: rtl/spi_pwm_expander_pkg.sv
// spi_pwm_expander_pkg: register map constants, address helpers and SPI FSM encoding
// shared by the expander top and its PWM channels.
package spi_pwm_expander_pkg;

    localparam logic [1:0] OFF_CTRL      = 2'd0;
    localparam logic [1:0] OFF_PERIOD    = 2'd1;
    localparam logic [1:0] OFF_DUTY      = 2'd2;
    localparam logic [1:0] OFF_STATUS    = 2'd3;
    localparam int         CH_STRIDE     = 4;
    localparam logic [6:0] ADDR_PRESCALE = 7'h7F;
    localparam int         CMD_READ_BIT  = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_WRDATA,
        ST_RDDATA
    } spi_state_e;

    function automatic logic [4:0] chan_of(input logic [6:0] a);
        return 5'(a / 7'(CH_STRIDE));
    endfunction

    function automatic logic [1:0] off_of(input logic [6:0] a);
        return 2'(a % 7'(CH_STRIDE));
    endfunction

endpackage

// File: rtl/spi_pwm_expander_pwm_channel.sv
// spi_pwm_expander_pwm_channel: one PWM channel with shadow/active PERIOD and DUTY,
// an 8-bit tick-driven counter, compare and output inversion.
module spi_pwm_expander_pwm_channel
    import spi_pwm_expander_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic       wr_i,
    input  logic [1:0] wr_off_i,
    input  logic [7:0] wr_data_i,
    output logic       en_o,
    output logic       inv_o,
    output logic [7:0] period_o,
    output logic [7:0] duty_o,
    output logic       pwm_o
);

    logic       en_q, en_d, inv_q, inv_d, wrap;
    logic [7:0] per_sh_q, per_sh_d, duty_sh_q, duty_sh_d;
    logic [7:0] per_act_q, per_act_d, duty_act_q, duty_act_d, cnt_q, cnt_d;

    assign wrap = tick_i && cnt_q == per_act_q;

    always_comb begin
        en_d       = (wr_i && wr_off_i == OFF_CTRL) ? wr_data_i[0] : en_q;
        inv_d      = (wr_i && wr_off_i == OFF_CTRL) ? wr_data_i[1] : inv_q;
        per_sh_d   = (wr_i && wr_off_i == OFF_PERIOD) ? wr_data_i : per_sh_q;
        duty_sh_d  = (wr_i && wr_off_i == OFF_DUTY) ? wr_data_i : duty_sh_q;
        // Active copies track the shadows while disabled, otherwise only at a wrap,
        // so a same-cycle SPI write is picked up at the following wrap.
        per_act_d  = (!en_q || wrap) ? per_sh_q : per_act_q;
        duty_act_d = (!en_q || wrap) ? duty_sh_q : duty_act_q;
        cnt_d      = (!en_q || wrap) ? 8'd0 : cnt_q + 8'(tick_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q       <= 1'b0;
            inv_q      <= 1'b0;
            per_sh_q   <= '0;
            duty_sh_q  <= '0;
            per_act_q  <= '0;
            duty_act_q <= '0;
            cnt_q      <= '0;
        end else begin
            en_q       <= en_d;
            inv_q      <= inv_d;
            per_sh_q   <= per_sh_d;
            duty_sh_q  <= duty_sh_d;
            per_act_q  <= per_act_d;
            duty_act_q <= duty_act_d;
            cnt_q      <= cnt_d;
        end
    end

    assign en_o     = en_q;
    assign inv_o    = inv_q;
    assign period_o = per_sh_q;
    assign duty_o   = duty_sh_q;
    assign pwm_o    = (en_q && cnt_q < duty_act_q) ^ inv_q;

endmodule

// File: rtl/spi_pwm_expander.sv
// spi_pwm_expander: oversampled SPI slave with command-based register R/W and
// address auto-increment, driving NumOfPWMOutputs double-buffered PWM channels.
module spi_pwm_expander
    import spi_pwm_expander_pkg::*;
#(
    parameter int NumOfPWMOutputs = 4,
    parameter int SyncStages      = 2,
    parameter int PrescaleWidth   = 8
) (
    input  logic                       CLK,
    input  logic                       _RST,
    input  logic                       _CS,
    input  logic                       SCLK,
    input  logic                       MOSI,
    output logic                       MISO,
    output logic [NumOfPWMOutputs-1:0] PWMOutputs
);

    // One extra stage on _CS/SCLK holds the previous synchronised sample for edge detection.
    logic [SyncStages:0]      cs_q, sclk_q;
    logic [SyncStages-1:0]    mosi_q;
    logic                     cs_s, cs_fall, cs_rise, sclk_rise, sclk_fall, byte_done, wr, tick;
    spi_state_e               state_q, state_d;
    logic [2:0]               bit_q, bit_d;
    logic [6:0]               rx_q, rx_d, addr_q, addr_d, rd_addr;
    logic [7:0]               tx_q, tx_d, byte_in, rd_data;
    logic                     rd_load_q, rd_load_d;
    logic [PrescaleWidth-1:0] pre_q, pre_d, pre_cnt_q, pre_cnt_d;
    logic [NumOfPWMOutputs-1:0] ch_en, ch_inv;
    logic [7:0]               ch_per  [NumOfPWMOutputs];
    logic [7:0]               ch_duty [NumOfPWMOutputs];

    assign cs_s      = cs_q[SyncStages-1];
    assign cs_fall   = cs_q[SyncStages] & ~cs_s;
    assign cs_rise   = ~cs_q[SyncStages] & cs_s;
    assign sclk_rise = ~sclk_q[SyncStages] & sclk_q[SyncStages-1];
    assign sclk_fall = sclk_q[SyncStages] & ~sclk_q[SyncStages-1];
    assign byte_in   = {rx_q, mosi_q[SyncStages-1]};
    assign byte_done = sclk_rise && bit_q == 3'd7;
    assign rd_addr   = (state_q == ST_CMD) ? byte_in[6:0] : addr_q;
    assign tick      = pre_cnt_q >= pre_q;
    assign MISO      = cs_s ? 1'bz : tx_q[7];

    always_comb begin
        rd_data = 8'h00;
        if (rd_addr == ADDR_PRESCALE) rd_data = 8'(pre_q);
        for (int n = 0; n < NumOfPWMOutputs; n++)
            if (chan_of(rd_addr) == 5'(n))
                rd_data = off_of(rd_addr) == OFF_CTRL   ? {6'b0, ch_inv[n], ch_en[n]} :
                          off_of(rd_addr) == OFF_PERIOD ? ch_per[n] :
                          off_of(rd_addr) == OFF_DUTY   ? ch_duty[n] :
                                                          {6'b0, PWMOutputs[n], ch_en[n]};
    end

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        rx_d      = rx_q;
        addr_d    = addr_q;
        tx_d      = tx_q;
        rd_load_d = rd_load_q;
        wr        = 1'b0;
        if (cs_rise) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_IDLE) begin
            if (cs_fall) begin
                state_d   = ST_CMD;
                bit_d     = 3'd0;
                tx_d      = 8'h00;
                rd_load_d = 1'b0;
            end
        end else begin
            if (sclk_rise) begin
                bit_d = bit_q + 3'd1;
                rx_d  = byte_in[6:0];
            end
            if (byte_done) begin
                case (state_q)
                    ST_CMD: begin
                        state_d = byte_in[CMD_READ_BIT] ? ST_RDDATA : ST_WRDATA;
                        addr_d  = byte_in[CMD_READ_BIT] ? byte_in[6:0] + 7'd1 : byte_in[6:0];
                        tx_d    = byte_in[CMD_READ_BIT] ? rd_data : tx_q;
                    end
                    ST_WRDATA: begin
                        wr     = 1'b1;
                        addr_d = addr_q + 7'd1;
                    end
                    default: rd_load_d = 1'b1;
                endcase
            end
            // The fall that closes the command byte leaves the freshly loaded MSB on MISO.
            if (sclk_fall && state_q == ST_RDDATA) begin
                tx_d      = rd_load_q ? rd_data : (bit_q != 3'd0 ? {tx_q[6:0], 1'b0} : tx_q);
                addr_d    = rd_load_q ? addr_q + 7'd1 : addr_q;
                rd_load_d = 1'b0;
            end
        end
        pre_d     = (wr && addr_q == ADDR_PRESCALE) ? PrescaleWidth'(byte_in) : pre_q;
        pre_cnt_d = tick ? '0 : pre_cnt_q + PrescaleWidth'(1);
    end

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            cs_q      <= '1;
            sclk_q    <= '0;
            mosi_q    <= '0;
            state_q   <= ST_IDLE;
            bit_q     <= '0;
            rx_q      <= '0;
            addr_q    <= '0;
            tx_q      <= '0;
            rd_load_q <= 1'b0;
            pre_q     <= '0;
            pre_cnt_q <= '0;
        end else begin
            cs_q      <= {cs_q[SyncStages-1:0], _CS};
            sclk_q    <= {sclk_q[SyncStages-1:0], SCLK};
            mosi_q    <= {mosi_q[SyncStages-2:0], MOSI};
            state_q   <= state_d;
            bit_q     <= bit_d;
            rx_q      <= rx_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
            rd_load_q <= rd_load_d;
            pre_q     <= pre_d;
            pre_cnt_q <= pre_cnt_d;
        end
    end

    for (genvar n = 0; n < NumOfPWMOutputs; n++) begin : g_ch
        spi_pwm_expander_pwm_channel u_ch (
            .clk_i    (CLK),
            .rst_ni   (_RST),
            .tick_i   (tick),
            .wr_i     (wr && chan_of(addr_q) == 5'(n)),
            .wr_off_i (off_of(addr_q)),
            .wr_data_i(byte_in),
            .en_o     (ch_en[n]),
            .inv_o    (ch_inv[n]),
            .period_o (ch_per[n]),
            .duty_o   (ch_duty[n]),
            .pwm_o    (PWMOutputs[n])
        );
    end

endmodule

// File: doc/spi_pwm_expander.md
Name: spi_pwm_expander

Overview:
Next-generation SPI-controlled PWM I/O expander: one CLK domain, NumOfPWMOutputs channels, full read/write register access over SPI.
- SPI pins are oversampled and synchronised into CLK, so the SPI clock drives no flops directly.
- Adds readback on MISO, command-based R/W, address auto-increment, and glitch-free double-buffered period/duty updates.
- Sits at the top of the design between the SPI pins and the PWM output pins.

Parameters:
NumOfPWMOutputs, 4, number of PWM channels (1..31).
SyncStages, 2, synchroniser depth for _CS/SCLK/MOSI (>=2).
PrescaleWidth, 8, width of the global prescaler register/counter.

Ports:
CLK  input  1  system clock; all state on posedge CLK.
_RST  input  1  asynchronous active-low reset.
_CS  input  1  SPI chip select, active low, asynchronous to CLK.
SCLK  input  1  SPI clock, mode 0, asynchronous; f_CLK >= 8*f_SCLK required.
MOSI  input  1  SPI data in.
MISO  output  1  SPI data out; high-Z while synchronised _CS is high.
PWMOutputs  output  NumOfPWMOutputs  PWM outputs, bit n = channel n.

Behaviour:
- Reset (_RST low, async): all registers 0; MISO high-Z; PWMOutputs 0; SPI FSM IDLE; partial byte discarded.
- Synchronisation: _CS, SCLK and MOSI each pass through SyncStages flops. SCLK rise/fall are detected from the last two synchronised samples.
- SPI FSM states: IDLE, CMD, WRDATA, RDDATA.
- IDLE -> CMD on synchronised _CS falling; bit counter cleared.
- Bits are sampled on SCLK rise, MSB first; a byte completes on the 8th rise.
- Command byte: bit7 = 1 read / 0 write; bits6:0 = start address A.
- CMD -> WRDATA or RDDATA on command byte completion.
- Any state -> IDLE on synchronised _CS rising. A partial byte is discarded and causes no write.
- Write: each completed data byte is written to register A in the cycle after completion; A then increments mod 128.
- Read: on command completion, reg[A] is loaded into the TX shifter, MISO drives its MSB immediately, and A increments. Following bits shift out on SCLK fall; after each 8th fall the next register is loaded.
- Latency from the 8th SCLK rise to register update: <= SyncStages+2 CLK.
- Register map, channel n base = 4n:
  - +0 CTRL: bit0 enable, bit1 invert, bits7:2 read 0.
  - +1 PERIOD (shadow).
  - +2 DUTY (shadow).
  - +3 STATUS (read-only): bit0 enabled, bit1 current output level.
- Address 0x7F PRESCALE: global tick asserted every PRESCALE+1 CLK cycles.
- Unmapped addresses and STATUS: writes ignored, reads return 0x00.
- Reads of PERIOD/DUTY return the shadow value.
- Channel counter: 8-bit, advances on tick through 0..PERIOD, then wraps to 0.
- Shadow-to-active copy:
  - at each wrap (counter == PERIOD on a tick), and
  - immediately while the channel is disabled.
- Raw output is high while counter < DUTY_active; PWMOutputs[n] = raw XOR invert.
  - DUTY = 0: constant low.
  - DUTY > PERIOD: constant high.
  - PERIOD = 0 and DUTY != 0: constant high.
- Disabled channel: counter held at 0; output = invert bit.
- Enable 0->1: counting starts from 0 on the next tick.
- Simultaneous SPI write and wrap: the copy takes the old shadow value; the new value applies at the following wrap.

Decomposition:
- Shared package: register offsets (CTRL=0, PERIOD=1, DUTY=2, STATUS=3), channel stride 4, PRESCALE address 0x7F, CMD read-bit index 7, SPI FSM state encoding.
- Sub-module pwm_channel: shadow/active registers, counter, compare, invert.
- Instantiated per channel via generate over NumOfPWMOutputs.

Test Plan:
- Reset, then write cmd 0x01 with data 0x09, 0x03 (PERIOD0=9, DUTY0=3), then 0x00 with data 0x01, PRESCALE=0 -> PWMOutputs[0] high 3 CLK, low 7 CLK, repeating.
- Channel 0 running, then write DUTY0=7 mid-period -> current period stays 3/10; the next period is 7/10 with no glitch.
- Write CTRL0=0x03 (enable + invert) on the above setup -> waveform inverted. Write CTRL0=0x02 -> output held high.
- Read burst with cmd 0x81 and 3 dummy bytes -> MISO returns 0x09, 0x07, then STATUS0 (bit0=1, bit1=current level).
- Assert _CS high after 4 bits of a data byte to address 0x05 -> PERIOD1 unchanged and FSM back in IDLE. Also assert _RST mid-read -> MISO high-Z, all outputs 0.
- Write to 0x7E, then read it -> reads 0x00. Burst write starting at 0x7F (2 bytes) -> PRESCALE set, address wraps, and the second byte lands in CTRL0.
